// File: rtl/mux2_tree_if.sv
// Bus bundle for the 4:1 mux tree: four data inputs, two selects, capture
// enable, plus the combinational and registered results.
interface mux2_tree_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic             s;
  logic             r;
  logic             en;
  logic [WIDTH-1:0] c_comb;
  logic [WIDTH-1:0] c;
  logic             c_vld;

  modport master (
    output a, b, d, e, s, r, en,
    input  c_comb, c, c_vld
  );

  modport slave (
    input  a, b, d, e, s, r, en,
    output c_comb, c, c_vld
  );
endinterface

// File: rtl/mux2_tree.sv
// 4:1 mux built from three 2:1 stages, with a zero-latency combinational
// result and an enable-gated registered copy plus a one-cycle valid strobe.
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

module mux2_tree #(
  parameter int WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  mux2_tree_if.slave  bus
);
  logic [WIDTH-1:0] m0;
  logic [WIDTH-1:0] m1;
  logic [WIDTH-1:0] c_comb;
  logic [WIDTH-1:0] c_q;
  logic             c_vld_q;

  // s picks within each pair, r then picks between the pairs.
  mux2 #(.WIDTH(WIDTH)) u_m0 (.sel(bus.s), .in0(bus.a), .in1(bus.b), .out(m0));
  mux2 #(.WIDTH(WIDTH)) u_m1 (.sel(bus.s), .in0(bus.d), .in1(bus.e), .out(m1));
  mux2 #(.WIDTH(WIDTH)) u_m2 (.sel(bus.r), .in0(m0),    .in1(m1),    .out(c_comb));

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; rst is checked first so it wins over en at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q     <= '0;
      c_vld_q <= 1'b0;
    end else begin
      if (bus.en) c_q <= c_comb;
      c_vld_q <= bus.en;
    end
  end

  assign bus.c_comb = c_comb;
  assign bus.c      = c_q;
  assign bus.c_vld  = c_vld_q;
endmodule

// File: tb/tb_mux2_tree.sv
// Self-checking bench for mux2_tree: WIDTH=1 and WIDTH=8 instances, a vector
// table, hand sequences for glitch/exhaustive cases, and a result scoreboard.
module tb_mux2_tree;
  logic clk = 1'b0;
  logic rst1, rst8;
  always #5 clk = ~clk;

  mux2_tree_if #(.WIDTH(1)) if1 ();
  mux2_tree_if #(.WIDTH(8)) if8 ();

  mux2_tree #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
  mux2_tree #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8));

  typedef struct {
    logic [7:0] a, b, d, e;
    logic       r, s, en, rst;
    logic [7:0] exp_comb;
  } vec_t;

  typedef struct {
    logic [7:0] c;
    logic       vld;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_c;
  logic       model_vld;
  int         n_total = 0;
  int         n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Independent reference: direct case on the 2-bit select.
  function automatic logic ref4(input logic a, b, d, e, r, s);
    case ({r, s})
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return d;
      default: return e;
    endcase
  endfunction

  // Advance the register model by one edge and queue its expected output.
  task automatic push_exp(input logic rst, input logic en, input logic [7:0] comb);
    exp_t x;
    if (rst) begin
      model_c = 8'h00; model_vld = 1'b0;
    end else begin
      if (en) model_c = comb;
      model_vld = en;
    end
    x.c = model_c; x.vld = model_vld;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input string name, input logic [7:0] c_act, input logic vld_act);
    exp_t x;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      x = sb.pop_front();
      check({name, "_c"}, {56'd0, c_act}, {56'd0, x.c});
      check({name, "_vld"}, {63'd0, vld_act}, {63'd0, x.vld});
    end
  endtask

  task automatic cyc8(input vec_t v, input string name);
    if8.a = v.a; if8.b = v.b; if8.d = v.d; if8.e = v.e;
    if8.r = v.r; if8.s = v.s; if8.en = v.en; rst8 = v.rst;
    #1 check({name, "_comb"}, {56'd0, if8.c_comb}, {56'd0, v.exp_comb});
    push_exp(v.rst, v.en, v.exp_comb);
    @(posedge clk); #1;
    pop_cmp(name, if8.c, if8.c_vld);
  endtask

  task automatic cyc1(input logic r, s, en, rst, input logic exp_comb, input string name);
    if1.r = r; if1.s = s; if1.en = en; rst1 = rst;
    #1 check({name, "_comb"}, {63'd0, if1.c_comb}, {63'd0, exp_comb});
    push_exp(rst, en, {7'd0, exp_comb});
    @(posedge clk); #1;
    pop_cmp(name, {7'd0, if1.c}, if1.c_vld);
  endtask

  vec_t vecs[12];

  initial begin
    //        a      b      d      e      r     s     en    rst   comb
    vecs[0]  = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[1]  = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33};
    vecs[2]  = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 8'h44};
    vecs[3]  = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[4]  = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22};
    vecs[5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33};
    vecs[6]  = '{8'h11, 8'h22, 8'h33, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF};
    vecs[7]  = '{8'h11, 8'h22, 8'h33, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[8]  = '{8'h11, 8'h22, 8'h33, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22};
    vecs[9]  = '{8'h5A, 8'h22, 8'h33, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A};
    vecs[10] = '{8'h5A, 8'hC3, 8'h33, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3};
    vecs[11] = '{8'h5A, 8'hC3, 8'h3C, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};

    rst1 = 1'b1; rst8 = 1'b1;
    if1.a = 1'b0; if1.b = 1'b0; if1.d = 1'b0; if1.e = 1'b0;
    if1.r = 1'b0; if1.s = 1'b0; if1.en = 1'b0;
    if8.a = '0; if8.b = '0; if8.d = '0; if8.e = '0;
    if8.r = 1'b0; if8.s = 1'b0; if8.en = 1'b0;
    model_c = 8'h00; model_vld = 1'b0;
    @(posedge clk); #1;

    // WIDTH=8 table: reset, capture, hold with en=0, rst-over-en, mid-op reset.
    for (int i = 0; i < 12; i++) cyc8(vecs[i], $sformatf("vec%0d", i));

    // Selects wiggle between edges and settle to 01 before the edge.
    if8.a = 8'h00; if8.b = 8'hA5; if8.d = 8'h0F; if8.e = 8'hF0;
    if8.en = 1'b1; rst8 = 1'b0;
    if8.r = 1'b1; if8.s = 1'b1;
    #1 check("glitch_comb_e", {56'd0, if8.c_comb}, 64'hF0);
    if8.r = 1'b1; if8.s = 1'b0;
    #1 check("glitch_comb_d", {56'd0, if8.c_comb}, 64'h0F);
    if8.r = 1'b0; if8.s = 1'b0;
    #1 check("glitch_comb_a", {56'd0, if8.c_comb}, 64'h00);
    if8.r = 1'b0; if8.s = 1'b1;
    #1 check("glitch_comb_b", {56'd0, if8.c_comb}, 64'hA5);
    push_exp(1'b0, 1'b1, 8'hA5);
    @(posedge clk); #1;
    pop_cmp("glitch", if8.c, if8.c_vld);
    if8.en = 1'b0;

    // WIDTH=1 sweep with capture, after its own reset.
    model_c = 8'h00; model_vld = 1'b0;
    if1.a = 1'b0; if1.b = 1'b1; if1.d = 1'b0; if1.e = 1'b1;
    cyc1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "w1_rst");
    cyc1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "w1_00");
    cyc1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "w1_01");
    cyc1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "w1_10");
    cyc1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "w1_11");
    cyc1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "w1_hold");

    // Exhaustive combinational check over all a,b,d,e,r,s.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      {if1.a, if1.b, if1.d, if1.e, if1.r, if1.s} = v;
      #1 check($sformatf("exh%0d", i), {63'd0, if1.c_comb},
               {63'd0, ref4(v[5], v[4], v[3], v[2], v[1], v[0])});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
